// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start qualification, mid-bit strobes, shift/parity/stop checks.
// Optional break detection with a wait-for-mark state is built when UART_RX_BREAK_EN is defined.
module uart_rx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int OS_W       = 4
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic       rx_en,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       receive_done,
  output logic       receive_frame_counter_en,
  output logic       receive_frame_counter_clear,
  output logic       sample_edge,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_det,
  output logic       rx_busy
);

`ifdef UART_RX_BREAK_EN
  typedef enum logic [1:0] {IDLE, START, DATA, WAIT_MARK} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA} state_t;
`endif

  localparam logic [OS_W-1:0] OS_MAX  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  state_t          state_q, state_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [8:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  // Received bits sit at the top of shreg; shift them down to bit 0 and mask to N.
  logic [3:0] n_bits, lsb_pos;
  logic [7:0] data_mask, data_al;
  assign n_bits    = 4'd5 + {2'b00, wls};
  assign lsb_pos   = 4'd9 - n_bits - {3'b000, pen};
  assign data_mask = 8'hFF >> (4'd8 - n_bits);
  assign data_al   = 8'(shreg_q >> lsb_pos) & data_mask;

`ifdef UART_RX_BREAK_EN
  logic brk_q, brk_d, brk_now;
  assign brk_now   = (data_al == 8'h00) & (~pen | ~shreg_q[8]) & ~rxd;
  assign break_det = brk_q;
`else
  assign break_det = 1'b0;
`endif

  assign sample_edge                 = baud_tick & (state_q == DATA) & (os_cnt_q == OS_MAX);
  assign receive_frame_counter_clear = (state_q == IDLE);
  assign receive_frame_counter_en    = sample_edge & ~receive_done;

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
`ifdef UART_RX_BREAK_EN
    brk_d      = brk_q;
`endif
    if (!rx_en) begin
      state_d  = IDLE;
      os_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (baud_tick && !rxd) begin
          state_d  = START;
          os_cnt_d = '0;
        end
        START: if (baud_tick) begin
          if (os_cnt_q == OS_HALF) begin
            os_cnt_d = '0;
            if (rxd) state_d = IDLE;
            else begin
              state_d = DATA;
              shreg_d = '0;
              par_d   = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        DATA: begin
          if (baud_tick) os_cnt_d = (os_cnt_q == OS_MAX) ? '0 : os_cnt_q + OS_W'(1);
          if (sample_edge && !receive_done) begin
            shreg_d = {rxd, shreg_q[8:1]};
            par_d   = par_q ^ rxd;
          end else if (sample_edge) begin
            // First stop bit: publish the character and re-arm mid-stop-bit.
            rx_data_d  = data_al;
            perr_d     = pen & (par_q ^ ~eps);
            ferr_d     = ~rxd;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
`ifdef UART_RX_BREAK_EN
            brk_d = brk_now;
            if (brk_now) state_d = WAIT_MARK;
`endif
          end
        end
`ifdef UART_RX_BREAK_EN
        WAIT_MARK: if (baud_tick && rxd) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_BREAK_EN
      brk_q      <= brk_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Receive-side sequencer for the UART RX path. Detects and qualifies the start bit from a 16x baud tick.
- Generates mid-bit sample strobes and drives the external frame counter and frame detector (counter enable, counter clear, sample edge; receive_done returned).
- Shifts in data and parity LSB-first, checks parity and stop bit, and presents one received character per frame to the RX FIFO/APB register block.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; even, >= 4.
- OS_W, 4, os_cnt width; must hold OVERSAMPLE-1.

Ports:
- pclk  in  1  clock.
- preset  in  1  synchronous active-high reset.
- baud_tick  in  1  one-pclk pulse at OVERSAMPLE x baud.
- rxd  in  1  serial input, already synchronised to pclk.
- rx_en  in  1  receiver enable.
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- pen  in  1  parity enable.
- eps  in  1  1=even parity, 0=odd parity.
- receive_done  in  1  from frame detector; high on the sample_edge where count equals data+parity width.
- receive_frame_counter_en  out  1  frame counter increment.
- receive_frame_counter_clear  out  1  frame counter clear.
- sample_edge  out  1  mid-bit sample strobe.
- rx_data  out  8  received character, zero-extended.
- rx_valid  out  1  one-cycle pulse: character available.
- parity_err  out  1  qualified by rx_valid.
- framing_err  out  1  qualified by rx_valid.
- break_det  out  1  qualified by rx_valid; only driven when the optional feature is built in.
- rx_busy  out  1  high when state != IDLE.

Behaviour:
- States: IDLE, START, DATA; WAIT_MARK only when UART_RX_BREAK_EN is defined.
- Reset (preset=1 at a pclk edge):
  - state=IDLE, os_cnt=0, shift register=0, parity accumulator=0.
  - rx_data=0, rx_valid=0, parity_err=0, framing_err=0, break_det=0.
- Start detection and qualification:
  - IDLE -> START when rx_en=1, baud_tick=1 and rxd=0. os_cnt<=0.
  - In START, os_cnt increments on each baud_tick.
  - On the baud_tick where os_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxd=0: go to DATA, os_cnt<=0.
    - rxd=1: false start, go to IDLE. No outputs pulse.
- DATA state:
  - os_cnt increments on baud_tick and wraps at OVERSAMPLE-1.
  - sample_edge = baud_tick & (state==DATA) & (os_cnt==OVERSAMPLE-1). This is combinational, one full bit period after the previous sample.
  - receive_frame_counter_clear = (state==IDLE), combinational. The counter therefore reads 0 on entry to DATA.
  - receive_frame_counter_en = sample_edge & ~receive_done.
  - On sample_edge with receive_done=0 (data or parity bit):
    - shreg[8:0] <= {rxd, shreg[8:1]}.
    - par <= par ^ rxd.
  - On sample_edge with receive_done=1 (first stop bit):
    - Register outputs; rx_valid=1 in the next cycle.
    - Go to IDLE, which re-arms start detection mid-stop-bit.
- Alignment and checks at receive_done. N = 5+wls; P = pen.
  - Received bits occupy shreg[8:9-(N+P)].
  - rx_data[N-1:0] = shreg[9-P-1 -: N], i.e. shreg[8-P:9-P-N]; upper bits are 0.
  - parity_err = P & (par ^ ~eps); the XOR over data+parity must be 0 for even, 1 for odd. parity_err=0 when pen=0.
  - framing_err = ~rxd at the stop sample.
- Second stop bit: never checked (16550-compatible).
- Config changes: wls, pen and eps are sampled live. Changing them mid-frame gives undefined data but no lockup.
- rx_en=0 in any state: next state is IDLE, os_cnt<=0, frame discarded, no rx_valid.
- preset mid-frame: same as reset, no rx_valid.
- baud_tick and receive_done coincidence: only meaningful with sample_edge. receive_done without sample_edge is ignored.
- rx_valid is never high on two consecutive cycles.
- Minimum gap between rx_valid pulses: (1 + N + P + 0.5) bit periods.
- Outputs hold their last values until the next rx_valid, except rx_valid itself.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined:
  - break_det = (data bits all 0) & (parity bit 0 or pen=0) & (stop sample rxd=0).
  - Asserted with rx_valid. rx_data=0; framing_err=1 as normal.
  - After a break frame, state goes to WAIT_MARK instead of IDLE.
  - WAIT_MARK -> IDLE on the first baud_tick with rxd=1. No further rx_valid while rxd stays low.
- Undefined:
  - break_det tied 0; WAIT_MARK absent.
  - A continuous low line produces repeated framing-error frames every N+P+1.5 bit periods.

Test Plan:
- 8N1 (wls=11, pen=0), rx_en=1, send 0xA5 at OVERSAMPLE=16 -> one rx_valid about 9.5 bit times after the start edge; rx_data=0xA5, parity_err=0, framing_err=0; exactly 8 counter_en pulses, then receive_done.
- 7E1 (wls=10, pen=1, eps=1), send 0x41 with parity bit forced 1 -> rx_data=0x41, parity_err=1; with correct parity 0 -> parity_err=0.
- 5O1 (wls=00, pen=1, eps=0), send 0x15 with stop bit forced 0 -> rx_data=0x15, framing_err=1, next state IDLE.
- rxd low glitch of 5 baud_ticks from IDLE -> return to IDLE at the mid-start check; no sample_edge, no rx_valid; a following valid 0x3C frame is received correctly.
- rx_en dropped after 4 data bits of an 8N1 frame -> rx_busy falls next cycle, no rx_valid; after rx_en=1, the next frame 0x7E is received correctly.
- UART_RX_BREAK_EN defined, rxd held low 30 bit times, then high -> one rx_valid with break_det=1, framing_err=1, rx_data=0; no further rx_valid until rxd is high; the next frame 0x55 is received normally.
